hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 73 +++++++
 tb/tb_hazard_scoreboard.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Register-dependency scoreboard for a 5-stage pipeline: tracks EX/MEM/WB writers and stalls ID on RAW hazards.
// Define FORWARDING_EN for a forwarding datapath, where only load-use stalls remain; leave it undefined for no forwarding.
module hazard_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_rn,
  input  logic [3:0]  id_rdm,
  input  logic        id_two_src,
  input  logic        id_wb_en,
  input  logic [3:0]  id_dest,
  input  logic        id_mem_read,
  input  logic        flush,
  input  logic        mem_ready,
  output logic        hazard,
  output logic        freeze,
  output logic [2:0]  sb_valid,
  output logic [15:0] stall_cycles
);

  typedef struct packed {
    logic       valid;
    logic [3:0] dest;
    logic       memRead;
  } entryT;

  entryT exEntry;
  entryT memEntry;
  entryT wbEntry;

  logic exMatch;
  logic unusedBits;

  function automatic logic matchEntry(input entryT e, input logic [3:0] rn,
                                      input logic [3:0] rdm, input logic twoSrc);
    return e.valid && ((rn == e.dest) || (twoSrc && (rdm == e.dest)));
  endfunction

  assign exMatch = matchEntry(exEntry, id_rn, id_rdm, id_two_src);

`ifdef FORWARDING_EN
  // Forwarding covers every producer except a load still in EX.
  assign hazard     = exMatch && exEntry.memRead;
  assign unusedBits = ^{memEntry.dest, memEntry.memRead, wbEntry.dest, wbEntry.memRead};
`else
  logic memMatch;

  // WB is never checked: the register file writes in the first half-cycle and ID reads in the second.
  assign memMatch   = matchEntry(memEntry, id_rn, id_rdm, id_two_src);
  assign hazard     = exMatch || memMatch;
  assign unusedBits = ^{memEntry.memRead, wbEntry.dest, wbEntry.memRead};
`endif

  assign freeze   = ~mem_ready;
  assign sb_valid = {wbEntry.valid, memEntry.valid, exEntry.valid};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exEntry      <= '0;
      memEntry     <= '0;
      wbEntry      <= '0;
      stall_cycles <= '0;
    end else if (mem_ready) begin
      // NOTE: non-blocking assignments make MEM take the old EX and WB the old MEM in the same edge.
      exEntry      <= '{valid: id_wb_en && !hazard && !flush, dest: id_dest, memRead: id_mem_read};
      memEntry     <= exEntry;
      wbEntry      <= memEntry;
      if (hazard && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: vector tables plus hand-driven reset, load-use and saturation sequences.
// Expected values switch with FORWARDING_EN so the same bench covers both builds.
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic [3:0]  id_rn;
  logic [3:0]  id_rdm;
  logic        id_two_src;
  logic        id_wb_en;
  logic [3:0]  id_dest;
  logic        id_mem_read;
  logic        flush;
  logic        mem_ready;
  logic        hazard;
  logic        freeze;
  logic [2:0]  sb_valid;
  logic [15:0] stall_cycles;

  hazard_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .id_rn        (id_rn),
    .id_rdm       (id_rdm),
    .id_two_src   (id_two_src),
    .id_wb_en     (id_wb_en),
    .id_dest      (id_dest),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .mem_ready    (mem_ready),
    .hazard       (hazard),
    .freeze       (freeze),
    .sb_valid     (sb_valid),
    .stall_cycles (stall_cycles)
  );

  typedef struct {
    logic [3:0]  rn;
    logic [3:0]  rdm;
    logic        twoSrc;
    logic        wbEn;
    logic [3:0]  dest;
    logic        memRead;
    logic        fl;
    logic        rdy;
    logic        expHazard;
    logic [2:0]  expSb;
    logic [15:0] expStall;
  } vecT;

  typedef struct {
    logic [2:0]  sb;
    logic [15:0] stall;
  } expT;

  vecT vecs[$];
  expT expQ[$];
  int  nChecks = 0;
  int  nFails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", nFails);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  function automatic vecT mk(input logic [3:0] rn, input logic [3:0] rdm, input logic twoSrc,
                             input logic wbEn, input logic [3:0] dest, input logic memRead,
                             input logic fl, input logic rdy, input logic expHazard,
                             input logic [2:0] expSb, input logic [15:0] expStall);
    vecT v;
    v.rn = rn; v.rdm = rdm; v.twoSrc = twoSrc; v.wbEn = wbEn; v.dest = dest;
    v.memRead = memRead; v.fl = fl; v.rdy = rdy; v.expHazard = expHazard;
    v.expSb = expSb; v.expStall = expStall;
    return v;
  endfunction

  task automatic driveIdle();
    id_rn = 4'd0; id_rdm = 4'd0; id_two_src = 1'b0; id_wb_en = 1'b0;
    id_dest = 4'd0; id_mem_read = 1'b0; flush = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    driveIdle();
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic applyVec(input vecT v, input string tag);
    expT e;
    @(negedge clk);
    id_rn = v.rn; id_rdm = v.rdm; id_two_src = v.twoSrc; id_wb_en = v.wbEn;
    id_dest = v.dest; id_mem_read = v.memRead; flush = v.fl; mem_ready = v.rdy;
    #1;
    check({tag, " hazard"}, 16'(hazard), 16'(v.expHazard));
    check({tag, " freeze"}, 16'(freeze), 16'(!v.rdy));
    expQ.push_back('{sb: v.expSb, stall: v.expStall});
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    check({tag, " sb_valid"}, 16'(sb_valid), 16'(e.sb));
    check({tag, " stall_cycles"}, stall_cycles, e.stall);
  endtask

  task automatic runVecs(input string prefix);
    for (int i = 0; i < vecs.size(); i++) begin
      applyVec(vecs[i], $sformatf("%s[%0d]", prefix, i));
    end
    vecs.delete();
  endtask

  initial begin
    logic wantLoad;
    logic isLoad;
    logic reached;

    rst = 1'b0;
    mem_ready = 1'b0;
    driveIdle();

    // Reset state, freeze following mem_ready while still in reset.
    #3;
    check("reset sb_valid", 16'(sb_valid), 16'd0);
    check("reset hazard", 16'(hazard), 16'd0);
    check("reset stall_cycles", stall_cycles, 16'd0);
    check("reset freeze rdy0", 16'(freeze), 16'd1);
    mem_ready = 1'b1;
    #1;
    check("reset freeze rdy1", 16'(freeze), 16'd0);

    // Main dependency table.
    doReset();
`ifdef FORWARDING_EN
    vecs.push_back(mk(4'd2, 4'd3, 1, 1, 4'd1, 0, 0, 1, 0, 3'b001, 16'd0)); // ADD r1
    vecs.push_back(mk(4'd1, 4'd3, 1, 1, 4'd2, 0, 0, 1, 0, 3'b011, 16'd0)); // SUB r2,r1,r3 forwarded
    vecs.push_back(mk(4'd0, 4'd0, 0, 1, 4'd4, 1, 0, 1, 0, 3'b111, 16'd0)); // LDR r4
    vecs.push_back(mk(4'd4, 4'd0, 1, 1, 4'd5, 0, 0, 1, 1, 3'b110, 16'd1)); // ADD r5,r4,r0 load-use
    vecs.push_back(mk(4'd4, 4'd0, 1, 1, 4'd5, 0, 0, 1, 0, 3'b101, 16'd1)); // retry issues
    vecs.push_back(mk(4'd5, 4'd0, 0, 1, 4'd6, 1, 0, 1, 0, 3'b011, 16'd1)); // LDR r6,[r5]
    vecs.push_back(mk(4'd0, 4'd6, 1, 0, 4'd0, 0, 0, 1, 1, 3'b110, 16'd2)); // STR r6 via rdm
    vecs.push_back(mk(4'd0, 4'd6, 1, 0, 4'd0, 0, 0, 1, 0, 3'b100, 16'd2));
    vecs.push_back(mk(4'd6, 4'd0, 0, 0, 4'd0, 0, 0, 1, 0, 3'b000, 16'd2)); // WB never stalls
`else
    vecs.push_back(mk(4'd2, 4'd3, 1, 1, 4'd1, 0, 0, 1, 0, 3'b001, 16'd0)); // ADD r1
    vecs.push_back(mk(4'd1, 4'd3, 1, 1, 4'd2, 0, 0, 1, 1, 3'b010, 16'd1)); // SUB r2,r1,r3 vs EX
    vecs.push_back(mk(4'd1, 4'd3, 1, 1, 4'd2, 0, 0, 1, 1, 3'b100, 16'd2)); // vs MEM
    vecs.push_back(mk(4'd1, 4'd3, 1, 1, 4'd2, 0, 0, 1, 0, 3'b001, 16'd2)); // WB: issues
    vecs.push_back(mk(4'd5, 4'd2, 0, 0, 4'd0, 0, 0, 1, 0, 3'b010, 16'd2)); // rdm not live
    vecs.push_back(mk(4'd5, 4'd2, 1, 0, 4'd0, 0, 0, 1, 1, 3'b100, 16'd3)); // rdm live vs MEM
    vecs.push_back(mk(4'd5, 4'd2, 1, 0, 4'd0, 0, 0, 1, 0, 3'b000, 16'd3)); // WB never stalls
    vecs.push_back(mk(4'd2, 4'd0, 0, 0, 4'd0, 0, 0, 1, 0, 3'b000, 16'd3)); // empty pipeline
`endif
    runVecs("dep");

    // Hazard pending while memory is not ready, including a flush inside the frozen window.
    doReset();
    vecs.push_back(mk(4'd0, 4'd0, 0, 1, 4'd3, 1, 0, 1, 0, 3'b001, 16'd0)); // LDR r3
    vecs.push_back(mk(4'd3, 4'd0, 0, 1, 4'd8, 0, 0, 0, 1, 3'b001, 16'd0));
    vecs.push_back(mk(4'd3, 4'd0, 0, 1, 4'd8, 0, 1, 0, 1, 3'b001, 16'd0));
    vecs.push_back(mk(4'd3, 4'd0, 0, 1, 4'd8, 0, 0, 0, 1, 3'b001, 16'd0));
    vecs.push_back(mk(4'd3, 4'd0, 0, 1, 4'd8, 0, 0, 1, 1, 3'b010, 16'd1));
`ifdef FORWARDING_EN
    vecs.push_back(mk(4'd3, 4'd0, 0, 1, 4'd8, 0, 0, 1, 0, 3'b101, 16'd1));
`else
    vecs.push_back(mk(4'd3, 4'd0, 0, 1, 4'd8, 0, 0, 1, 1, 3'b100, 16'd2));
    vecs.push_back(mk(4'd3, 4'd0, 0, 1, 4'd8, 0, 0, 1, 0, 3'b001, 16'd2));
`endif
    runVecs("frz");

    // Flushed writers never enter the scoreboard.
    doReset();
    vecs.push_back(mk(4'd0, 4'd0, 0, 1, 4'd7, 0, 1, 1, 0, 3'b000, 16'd0)); // flushed write r7
    vecs.push_back(mk(4'd7, 4'd7, 1, 0, 4'd0, 0, 0, 1, 0, 3'b000, 16'd0)); // read r7
    vecs.push_back(mk(4'd0, 4'd0, 0, 1, 4'd9, 0, 0, 1, 0, 3'b001, 16'd0)); // write r9
    vecs.push_back(mk(4'd0, 4'd0, 0, 1, 4'd7, 1, 1, 1, 0, 3'b010, 16'd0)); // flushed LDR r7
    vecs.push_back(mk(4'd7, 4'd0, 0, 0, 4'd0, 0, 0, 1, 0, 3'b100, 16'd0)); // read r7
    runVecs("fls");

    // Build up five stall cycles with load-use pairs, then reset asynchronously mid-cycle.
    doReset();
    wantLoad = 1'b1;
    reached  = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      isLoad = wantLoad;
      if (wantLoad) begin
        id_rn = 4'd0; id_two_src = 1'b0; id_wb_en = 1'b1; id_dest = 4'd4; id_mem_read = 1'b1;
        wantLoad = 1'b0;
      end else begin
        id_rn = 4'd4; id_two_src = 1'b0; id_wb_en = 1'b1; id_dest = 4'd5; id_mem_read = 1'b0;
      end
      #1;
      if (!isLoad && !hazard) wantLoad = 1'b1;
      @(posedge clk);
      #1;
      if (stall_cycles == 16'd5) begin
        reached = 1'b1;
        break;
      end
    end
    check("stall count reached 5", 16'(reached), 16'd1);
    check("pre-reset sb_valid nonzero", 16'(sb_valid != 3'b000), 16'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async reset sb_valid", 16'(sb_valid), 16'd0);
    check("async reset hazard", 16'(hazard), 16'd0);
    check("async reset stall_cycles", stall_cycles, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post-reset dependent hazard", 16'(hazard), 16'd0);
    @(posedge clk);
    #1;
    check("post-reset stall_cycles", stall_cycles, 16'd0);
    check("post-reset sb_valid", 16'(sb_valid), 16'd1);

    // Saturation of the stall counter under a permanently asserted hazard.
    doReset();
    force dut.hazard = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    check("stall_cycles one below max", stall_cycles, 16'hFFFE);
    @(posedge clk);
    #1;
    check("stall_cycles reaches max", stall_cycles, 16'hFFFF);
    repeat (70000 - 65535) @(posedge clk);
    #1;
    check("stall_cycles saturated", stall_cycles, 16'hFFFF);
    release dut.hazard;
    doReset();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
